// File: rtl/tone_synth_pkg.sv
// rtl/tone_synth_pkg.sv - shared note table, voice state type and half-period helper for tone_synth
package tone_synth_pkg;

    // Base frequencies in Hz indexed by note code; code 0 is the silent note.
    localparam int unsigned BASE_FREQ_HZ [8] = '{0, 33, 37, 41, 44, 49, 55, 62};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    // Octaves 0 and 1 share the base pitch; each higher octave halves the period.
    function automatic int unsigned tone_half_period(
        input int unsigned clk_hz,
        input logic [2:0]  note,
        input logic [2:0]  octave
    );
        int unsigned hp;
        hp = 0;
        if (note != 3'd0) begin
            hp = clk_hz / (2 * BASE_FREQ_HZ[note]);
            if (octave > 3'd1) begin
                hp = hp >> (octave - 3'd1);
            end
        end
        return hp;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one voice: key FSM, half-period divider and amplitude (RELEASE state with TONE_SYNTH_DECAY_EN)
module tone_voice
    import tone_synth_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int AMP_W  = 4,
    parameter int DIV_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [2:0]       key_note,
    input  logic [2:0]       key_octave,
`ifdef TONE_SYNTH_DECAY_EN
    input  logic             decay_pulse,
`endif
    output logic             busy,
    output logic             sq,
    output logic [AMP_W-1:0] amp
);

    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    voice_state_t     state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic             sq_q, sq_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic [2:0]       note_q, note_d;
    logic [2:0]       oct_q, oct_d;
    logic             keyed;
    logic             retune;
    logic             trigger;

    // Every note/octave pair resolves to a constant, so the runtime lookup is a plain mux.
    logic [DIV_W-1:0] hp_lut [64];
    for (genvar n = 0; n < 8; n++) begin : g_hp_note
        for (genvar o = 0; o < 8; o++) begin : g_hp_oct
            assign hp_lut[n*8 + o] = DIV_W'(tone_half_period(int'(CLK_HZ), 3'(n), 3'(o)));
        end
    end

    assign keyed = key_valid && (key_note != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= DIV_W'(1);
            hp_q    <= '0;
            sq_q    <= 1'b0;
            amp_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            sq_q    <= sq_d;
            amp_q   <= amp_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        sq_d    = sq_q;
        amp_d   = amp_q;
        note_d  = note_q;
        oct_d   = oct_q;
        trigger = 1'b0;
        retune  = 1'b0;

        if (state_q != IDLE) begin
            if (cnt_q == hp_q) begin
                cnt_d = DIV_W'(1);
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (keyed) begin
                    state_d = PLAY;
                    trigger = 1'b1;
                end
            end
            PLAY: begin
                if (!keyed) begin
`ifdef TONE_SYNTH_DECAY_EN
                    state_d = RELEASE;
`else
                    state_d = IDLE;
                    amp_d   = '0;
                    sq_d    = 1'b0;
                    cnt_d   = DIV_W'(1);
`endif
                end else if ((key_note != note_q) || (key_octave != oct_q)) begin
                    retune = 1'b1;
                end
            end
`ifdef TONE_SYNTH_DECAY_EN
            RELEASE: begin
                if (keyed) begin
                    state_d = PLAY;
                    trigger = 1'b1;
                end else if (decay_pulse) begin
                    if (amp_q <= AMP_W'(1)) begin
                        state_d = IDLE;
                        amp_d   = '0;
                        sq_d    = 1'b0;
                        cnt_d   = DIV_W'(1);
                    end else begin
                        amp_d = amp_q - AMP_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (trigger || retune) begin
            hp_d   = hp_lut[{key_note, key_octave}];
            cnt_d  = DIV_W'(1);
            sq_d   = 1'b1;
            note_d = key_note;
            oct_d  = key_octave;
        end
        if (trigger) begin
            amp_d = AMP_MAX;
        end
    end

    assign busy = (state_q != IDLE);
    assign sq   = sq_q;
    assign amp  = amp_q;

endmodule

// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - polyphonic square-wave synth with PWM amp driver (decay via TONE_SYNTH_DECAY_EN)
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int N_VOICES    = 4,
    parameter int AMP_W       = 4,
    parameter int DIV_W       = 32,
    parameter int DECAY_TICKS = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_VOICES-1:0]   key_valid,
    input  logic [3*N_VOICES-1:0] key_note,
    input  logic [3*N_VOICES-1:0] key_octave,
    output logic [N_VOICES-1:0]   voice_busy,
    output logic                  AIN,
    output logic                  GAIN,
    output logic                  NC,
    output logic                  ACTIVE
);

    localparam int MIX_W = AMP_W + $clog2(N_VOICES);

    logic [N_VOICES-1:0] sq;
    logic [AMP_W-1:0]    amp [N_VOICES];
    logic [MIX_W-1:0]    mix_sum;
    logic [MIX_W-1:0]    level_q;
    logic [MIX_W-1:0]    pwm_cnt_q;

`ifdef TONE_SYNTH_DECAY_EN
    localparam int DECAY_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    logic [DECAY_W-1:0] decay_cnt_q;
    logic               decay_pulse;

    assign decay_pulse = (decay_cnt_q == DECAY_W'(DECAY_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || decay_pulse) begin
            decay_cnt_q <= '0;
        end else begin
            decay_cnt_q <= decay_cnt_q + DECAY_W'(1);
        end
    end
`else
    localparam int unused_decay_ticks = DECAY_TICKS;
`endif

    for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
        tone_voice #(
            .CLK_HZ (CLK_HZ),
            .AMP_W  (AMP_W),
            .DIV_W  (DIV_W)
        ) u_voice (
            .clk        (clk),
            .rst        (rst),
            .key_valid  (key_valid[i]),
            .key_note   (key_note[3*i +: 3]),
            .key_octave (key_octave[3*i +: 3]),
`ifdef TONE_SYNTH_DECAY_EN
            .decay_pulse(decay_pulse),
`endif
            .busy       (voice_busy[i]),
            .sq         (sq[i]),
            .amp        (amp[i])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (sq[i]) begin
                mix_sum = mix_sum + MIX_W'(amp[i]);
            end
        end
    end

    // pwm_cnt wraps naturally, so a full-scale level still leaves one low slot per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            pwm_cnt_q <= '0;
            AIN       <= 1'b0;
            ACTIVE    <= 1'b0;
        end else begin
            level_q   <= mix_sum;
            pwm_cnt_q <= pwm_cnt_q + MIX_W'(1);
            AIN       <= (pwm_cnt_q < level_q);
            ACTIVE    <= |voice_busy;
        end
    end

    assign GAIN = 1'b1;
    assign NC   = 1'b0;

endmodule
